// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Single-outstanding load/store responder in front of a small word memory.
//   Each accepted request passes through a programmable number of wait
//   states, performs the access, then holds its response until the
//   controller takes it. There is no pipelining: one request at a time.
//
// Parameters
//   DEPTH_LOG2  : memory holds 2**DEPTH_LOG2 words of 16 bits (4..12)
//   WAIT_CYCLES : wait states inserted per access (0..15)
//
// Ports
//   i_clock       : single clock, rising edge
//   i_reset       : synchronous active-high reset
//   i_req_valid   : controller presents a request
//   o_req_ready   : responder can accept a request (IDLE only)
//   i_req_write   : 1 = store, 0 = load
//   i_req_addr    : word address
//   i_req_wdata   : store data
//   o_rsp_valid   : response presented
//   i_rsp_ready   : controller accepts the response
//   o_rsp_rdata   : load data (0 for stores and errors)
//   o_rsp_err     : address was outside the memory
//   o_busy        : high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [15:0] i_req_addr,
  input  logic [15:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [15:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic        o_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  // Counter start value; unused when WAIT_CYCLES is 0 (ACCESS is entered directly).
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [15:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_busy;
  logic [15:0] r_mem [DEPTH];

  logic                  w_accept;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_index;

  assign w_accept   = i_req_valid & r_req_ready;
  // In range when no address bit at or above DEPTH_LOG2 is set.
  assign w_in_range = ((r_addr >> DEPTH_LOG2) == 16'd0);
  assign w_index    = r_addr[DEPTH_LOG2-1:0];

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;
  assign o_busy      = r_busy;

  // Request latch: captured only on acceptance, so inputs are ignored while busy.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_write <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
    end else if (w_accept) begin
      r_write <= i_req_write;
      r_addr  <= i_req_addr;
      r_wdata <= i_req_wdata;
    end else begin
      r_write <= r_write;
      r_addr  <= r_addr;
      r_wdata <= r_wdata;
    end
  end

  // Control FSM with registered handshake, response and busy outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 16'd0;
      r_rsp_err   <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              r_state <= ST_ACCESS;
            end else begin
              r_state <= ST_WAIT;
              r_cnt   <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          // The cycle that sees a zero count is the last wait state.
          if (r_cnt == 4'd0) begin
            r_state <= ST_ACCESS;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_ACCESS: begin
          r_state     <= ST_RESP;
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= ~w_in_range;
          r_rsp_rdata <= (!r_write && w_in_range) ? r_mem[w_index] : 16'd0;
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_state     <= ST_IDLE;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 16'd0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= 4'd0;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
          r_rsp_rdata <= 16'd0;
          r_rsp_err   <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port: no reset so contents survive it, and a reset edge
  // during ACCESS abandons the store.
  always_ff @(posedge i_clock) begin
    if (!i_reset && (r_state == ST_ACCESS) && r_write && w_in_range) begin
      r_mem[w_index] <= r_wdata;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Self-checking bench for mem_responder. A default instance (DEPTH_LOG2=8,
//   WAIT_CYCLES=2) is exercised with a directed vector table, reset-abort
//   sequences, a continuous-valid stream and randomized transactions checked
//   against an array model of the memory. Two more instances (WAIT_CYCLES=0
//   and 15) check response latency.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, rsp_ready;
  logic [15:0] req_addr, req_wdata;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [15:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_rsp_valid, z_rsp_err, z_busy;
  logic [15:0] z_rsp_rdata;
  logic        f_req_valid, f_req_ready, f_rsp_valid, f_rsp_err, f_busy;
  logic [15:0] f_rsp_rdata;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W)) u_dut (
    .i_clock(clk), .i_reset(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(rsp_rdata),
    .o_rsp_err(rsp_err), .o_busy(busy));

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut_w0 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(z_req_valid), .o_req_ready(z_req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(z_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(z_rsp_rdata),
    .o_rsp_err(z_rsp_err), .o_busy(z_busy));

  mem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(15)) u_dut_w15 (
    .i_clock(clk), .i_reset(rst), .i_req_valid(f_req_valid), .o_req_ready(f_req_ready),
    .i_req_write(req_write), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(f_rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_rdata(f_rsp_rdata),
    .o_rsp_err(f_rsp_err), .o_busy(f_busy));

  int checks   = 0;
  int failures = 0;

  // Reference memory: word contents plus a written flag (unwritten = unknown).
  logic [15:0] m_mem [DEPTH];
  bit          m_vld [DEPTH];

  typedef struct {
    bit          wr;
    logic [15:0] addr;
    logic [15:0] wd;
    int          hold;
    logic        exp_err;
    logic [15:0] exp_rd;
  } vec_t;

  typedef struct {
    bit          known;
    logic        err;
    logic [15:0] rd;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model prediction for one request; updates the model for in-range stores.
  task automatic predict(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                         output exp_t e);
    bit in_r;
    in_r    = (addr < 16'd256);
    e.err   = !in_r;
    e.known = wr || !in_r || m_vld[addr[7:0]];
    e.rd    = (!wr && in_r) ? m_mem[addr[7:0]] : 16'd0;
    if (wr && in_r) begin
      m_mem[addr[7:0]] = wd;
      m_vld[addr[7:0]] = 1'b1;
    end
  endtask

  // One full transaction on the default instance, with latency/handshake checks.
  task automatic txn(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                     input int hold, output logic [15:0] rd, output logic er);
    int n;
    int g;
    logic [15:0] hrd;
    logic        her;
    g = 0;
    while (!req_ready && g < 50) begin
      step();
      g++;
    end
    chk("idle_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    step();
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = 16'($urandom);
    req_wdata = 16'($urandom);
    n = 1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    while (!rsp_valid && n < 40) begin
      chk("no_ready_in_flight", {31'd0, req_ready}, 32'd0);
      step();
      n++;
    end
    chk("latency", n, W + 2);
    rd  = rsp_rdata;
    er  = rsp_err;
    hrd = rsp_rdata;
    her = rsp_err;
    chk("ready_vs_valid", {31'd0, req_ready}, 32'd0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_rdata", {16'd0, rsp_rdata}, {16'd0, hrd});
      chk("hold_err", {31'd0, rsp_err}, {31'd0, her});
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("done_valid", {31'd0, rsp_valid}, 32'd0);
    chk("done_ready", {31'd0, req_ready}, 32'd1);
    chk("done_busy", {31'd0, busy}, 32'd0);
  endtask

  vec_t        vt [10];
  exp_t        e;
  exp_t        q [$];
  logic [15:0] rd;
  logic        er;
  int          k, got, zn, fn;
  logic        z_er, f_er;
  logic [15:0] z_rd, f_rd;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{1'b1, 16'h0000, 16'h5A5A, 0, 1'b0, 16'h0000};
    vt[1] = '{1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 16'h0000};
    vt[2] = '{1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'hBEEF};
    vt[3] = '{1'b0, 16'h0100, 16'h0000, 0, 1'b1, 16'h0000};
    vt[4] = '{1'b1, 16'h0100, 16'h1111, 1, 1'b1, 16'h0000};
    vt[5] = '{1'b0, 16'h0000, 16'h0000, 5, 1'b0, 16'h5A5A};
    vt[6] = '{1'b1, 16'h00FF, 16'hA5A5, 0, 1'b0, 16'h0000};
    vt[7] = '{1'b0, 16'h00FF, 16'h0000, 0, 1'b0, 16'hA5A5};
    vt[8] = '{1'b0, 16'hFFFF, 16'h0000, 2, 1'b1, 16'h0000};
    vt[9] = '{1'b1, 16'h0020, 16'h1234, 0, 1'b0, 16'h0000};

    for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;

    rst = 1'b1;
    req_valid = 1'b0; z_req_valid = 1'b0; f_req_valid = 1'b0;
    req_write = 1'b0; req_addr = 16'd0; req_wdata = 16'd0; rsp_ready = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      predict(vt[i].wr, vt[i].addr, vt[i].wd, e);
      txn(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].hold, rd, er);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, vt[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), {16'd0, rd}, {16'd0, vt[i].exp_rd});
    end

    // Reset during WAIT abandons the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hFFFF;
    step();
    req_valid = 1'b0;
    chk("abort_wait_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_wait_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_wait_busy0", {31'd0, busy}, 32'd0);
    chk("abort_wait_valid", {31'd0, rsp_valid}, 32'd0);
    txn(1'b0, 16'h0020, 16'h0000, 0, rd, er);
    chk("abort_wait_mem", {16'd0, rd}, 32'h1234);

    // Reset during ACCESS abandons the store.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0020; req_wdata = 16'hEEEE;
    step();
    req_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_acc_ready", {31'd0, req_ready}, 32'd1);
    txn(1'b0, 16'h0020, 16'h0000, 0, rd, er);
    chk("abort_acc_mem", {16'd0, rd}, 32'h1234);
    chk("abort_acc_err", {31'd0, er}, 32'd0);

    // Continuous req_valid: only IDLE accepts, responses in request order.
    k = 0; got = 0; rsp_ready = 1'b1;
    for (int c = 0; c < 300 && got < 10; c++) begin
      chk("ready_vs_valid_stream", {31'd0, rsp_valid & req_ready}, 32'd0);
      if (rsp_valid) begin
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("stream_err", {31'd0, rsp_err}, {31'd0, e.err});
          if (e.known) chk("stream_rdata", {16'd0, rsp_rdata}, {16'd0, e.rd});
        end else begin
          chk("stream_unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        got++;
      end
      if (req_ready && k < 10) begin
        req_valid = 1'b1;
        req_write = (k % 2 == 0);
        req_addr  = (k >= 8) ? 16'h1000 : 16'(16'h0040 + 16'(k / 2));
        req_wdata = 16'($urandom);
        predict(req_write, req_addr, req_wdata, e);
        q.push_back(e);
        k++;
      end else if (k < 10) begin
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
      end else begin
        req_valid = 1'b0;
      end
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("stream_count", got, 10);

    // Randomized transactions against the model.
    for (int i = 0; i < 40; i++) begin
      bit          wr;
      logic [15:0] a, d;
      int          hold;
      wr   = 1'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(256, 65535))
                                         : 16'($urandom_range(0, 255));
      d    = 16'($urandom);
      hold = $urandom_range(0, 3);
      predict(wr, a, d, e);
      txn(wr, a, d, hold, rd, er);
      chk("rand_err", {31'd0, er}, {31'd0, e.err});
      if (e.known) chk("rand_rdata", {16'd0, rd}, {16'd0, e.rd});
    end

    // Latency for WAIT_CYCLES = 0 and 15 (out-of-range load, defined result).
    chk("w0_ready", {31'd0, z_req_ready}, 32'd1);
    chk("w15_ready", {31'd0, f_req_ready}, 32'd1);
    req_write = 1'b0; req_addr = 16'h0100; rsp_ready = 1'b1;
    z_req_valid = 1'b1; f_req_valid = 1'b1;
    step();
    z_req_valid = 1'b0; f_req_valid = 1'b0;
    zn = 0; fn = 0; z_er = 1'b0; f_er = 1'b0; z_rd = 16'hDEAD; f_rd = 16'hDEAD;
    for (int n = 1; n < 40 && fn == 0; n++) begin
      if (z_rsp_valid && zn == 0) begin zn = n; z_er = z_rsp_err; z_rd = z_rsp_rdata; end
      if (f_rsp_valid && fn == 0) begin fn = n; f_er = f_rsp_err; f_rd = f_rsp_rdata; end
      if (fn == 0) step();
    end
    rsp_ready = 1'b0;
    chk("w0_latency", zn, 2);
    chk("w15_latency", fn, 17);
    chk("w0_err", {31'd0, z_er}, 32'd1);
    chk("w0_rdata", {16'd0, z_rd}, 32'd0);
    chk("w15_err", {31'd0, f_er}, 32'd1);
    chk("w15_rdata", {16'd0, f_rd}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
